// File: rtl/dma_pkg.sv
// Shared definitions for the DMA register file: control offsets, channel register
// selects, mode field layout and byte-lane helpers used by the channel registers.
package dma_pkg;

  localparam logic [2:0] OFF_CMD      = 3'd0;
  localparam logic [2:0] OFF_REQ      = 3'd1;
  localparam logic [2:0] OFF_MASK     = 3'd2;
  localparam logic [2:0] OFF_CLR_PTR  = 3'd3;
  localparam logic [2:0] OFF_MCLR     = 3'd4;
  localparam logic [2:0] OFF_CLR_MASK = 3'd5;
  localparam logic [2:0] OFF_ALL_MASK = 3'd6;

  localparam logic [1:0] SEL_ADDR  = 2'd0;
  localparam logic [1:0] SEL_COUNT = 2'd1;
  localparam logic [1:0] SEL_MODE  = 2'd2;

  localparam int unsigned MODE_W            = 32'd6;
  localparam int unsigned MODE_TYPE_LSB     = 32'd0;
  localparam int unsigned MODE_AUTOINIT_BIT = 32'd2;
  localparam int unsigned MODE_DECR_BIT     = 32'd3;
  localparam int unsigned MODE_XFER_LSB     = 32'd4;

  typedef struct packed {
    logic [1:0] xfer_mode;
    logic       decr;
    logic       autoinit;
    logic [1:0] xfer_type;
  } mode_t;

  // Bits written above the real register width are dropped by the caller's cast.
  function automatic logic [31:0] set_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] data);
    logic [31:0] res;
    res = word;
    res[{idx, 3'b000} +: 8] = data;
    return res;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] ptr, input logic [1:0] last);
    return (ptr >= last) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/dma_chan_regs.sv
// One DMA channel: base/current address and count registers, CPU byte loads and
// per-transfer address step / count decrement with terminal-count handling.
module dma_chan_regs
  import dma_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               mclr_i,
  input  logic               addr_wr_i,
  input  logic               count_wr_i,
  input  logic [1:0]         ptr_i,
  input  logic [7:0]         wdata_i,
  input  logic               upd_i,
  input  logic               decr_i,
  input  logic               autoinit_i,
  output logic [ADDR_W-1:0]  curr_addr_o,
  output logic [COUNT_W-1:0] curr_count_o,
  output logic               tc_o
);

  logic [ADDR_W-1:0]  base_addr_q, base_addr_d, curr_addr_q, curr_addr_d;
  logic [COUNT_W-1:0] base_count_q, base_count_d, curr_count_q, curr_count_d;

  assign tc_o         = upd_i && (curr_count_q == '0);
  assign curr_addr_o  = curr_addr_q;
  assign curr_count_o = curr_count_q;

  // Next state: transfer update first, then a CPU byte write overrides its own register.
  always_comb begin
    base_addr_d  = base_addr_q;
    base_count_d = base_count_q;
    if (upd_i) begin
      if (tc_o && autoinit_i) begin
        curr_addr_d  = base_addr_q;
        curr_count_d = base_count_q;
      end else begin
        curr_addr_d  = decr_i ? curr_addr_q - ADDR_W'(1) : curr_addr_q + ADDR_W'(1);
        curr_count_d = curr_count_q - COUNT_W'(1);
      end
    end else begin
      curr_addr_d  = curr_addr_q;
      curr_count_d = curr_count_q;
    end
    if (addr_wr_i) begin
      base_addr_d = ADDR_W'(set_byte(32'(base_addr_q), ptr_i, wdata_i));
      curr_addr_d = ADDR_W'(set_byte(32'(curr_addr_q), ptr_i, wdata_i));
    end else begin
      base_addr_d = base_addr_q;
    end
    if (count_wr_i) begin
      base_count_d = COUNT_W'(set_byte(32'(base_count_q), ptr_i, wdata_i));
      curr_count_d = COUNT_W'(set_byte(32'(curr_count_q), ptr_i, wdata_i));
    end else begin
      base_count_d = base_count_q;
    end
  end

  // Channel register state with master-clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_addr_q  <= '0;
      curr_addr_q  <= '0;
      base_count_q <= '0;
      curr_count_q <= '0;
    end else if (mclr_i) begin
      base_addr_q  <= '0;
      curr_addr_q  <= '0;
      base_count_q <= '0;
      curr_count_q <= '0;
    end else begin
      base_addr_q  <= base_addr_d;
      curr_addr_q  <= curr_addr_d;
      base_count_q <= base_count_d;
      curr_count_q <= curr_count_d;
    end
  end

endmodule

// File: rtl/dma_reg_file.sv
// DMA controller register file: CPU byte-wide access to per-channel address/count/mode
// registers and the global command, request, mask and terminal-count state.
module dma_reg_file
  import dma_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 16,
  parameter int COUNT_W = 16,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        cpu_wr,
  input  logic                        cpu_rd,
  input  logic [CH_W+2:0]             cpu_addr,
  input  logic [7:0]                  cpu_wdata,
  output logic [7:0]                  cpu_rdata,
  input  logic                        upd_valid,
  input  logic [CH_W-1:0]             upd_ch,
  output logic [NUM_CH*ADDR_W-1:0]    curr_addr,
  output logic [NUM_CH*COUNT_W-1:0]   curr_count,
  output logic [NUM_CH*6-1:0]         mode,
  output logic [7:0]                  command,
  output logic [NUM_CH-1:0]           mask,
  output logic [NUM_CH-1:0]           sw_req,
  output logic [NUM_CH-1:0]           tc_pulse
);

  localparam int NBA = (ADDR_W + 7) / 8;
  localparam int NBC = (COUNT_W + 7) / 8;
  localparam logic [1:0] LAST_A = 2'(NBA - 1);
  localparam logic [1:0] LAST_C = 2'(NBC - 1);

  logic                   wr_s, rd_s, ctrl_s, chan_wr_s, chan_acc_s, ctrl_wr_s, ctrl_rd_s, mclr_s;
  logic [CH_W-1:0]        ch_s;
  logic [1:0]             sel_s;
  logic [2:0]             off_s;
  mode_t                  wmode_s;
  logic [ADDR_W-1:0]      ca_s [NUM_CH];
  logic [COUNT_W-1:0]     cc_s [NUM_CH];
  logic [NUM_CH-1:0]      tc_hit_s, autoinit_s;

  logic [NUM_CH*6-1:0]    mode_q, mode_d;
  logic [7:0]             command_q, command_d, rdata_q, rdata_d;
  logic [NUM_CH-1:0]      mask_q, mask_d, sw_req_q, sw_req_d, tc_q, tc_d, tc_pulse_q, tc_pulse_d;
  logic [1:0]             ptr_q, ptr_d;

  // Simultaneous read and write strobes cancel each other out.
  assign wr_s       = cpu_wr && !cpu_rd;
  assign rd_s       = cpu_rd && !cpu_wr;
  assign ctrl_s     = cpu_addr[CH_W+2];
  assign ch_s       = cpu_addr[CH_W+1:2];
  assign sel_s      = cpu_addr[1:0];
  assign off_s      = cpu_addr[2:0];
  assign chan_wr_s  = wr_s && !ctrl_s;
  assign chan_acc_s = (wr_s || rd_s) && !ctrl_s;
  assign ctrl_wr_s  = wr_s && ctrl_s;
  assign ctrl_rd_s  = rd_s && ctrl_s;
  assign mclr_s     = ctrl_wr_s && (off_s == OFF_MCLR);
  assign wmode_s    = mode_t'(cpu_wdata[5:0]);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign autoinit_s[g] = mode_q[g*MODE_W + MODE_AUTOINIT_BIT];
    dma_chan_regs #(.ADDR_W(ADDR_W), .COUNT_W(COUNT_W)) u_regs (
      .clk_i       (CLK),
      .rst_ni      (RESET),
      .mclr_i      (mclr_s),
      .addr_wr_i   (chan_wr_s && (ch_s == CH_W'(g)) && (sel_s == SEL_ADDR)),
      .count_wr_i  (chan_wr_s && (ch_s == CH_W'(g)) && (sel_s == SEL_COUNT)),
      .ptr_i       (ptr_q),
      .wdata_i     (cpu_wdata),
      .upd_i       (upd_valid && (upd_ch == CH_W'(g))),
      .decr_i      (mode_q[g*MODE_W + MODE_DECR_BIT]),
      .autoinit_i  (autoinit_s[g]),
      .curr_addr_o (ca_s[g]),
      .curr_count_o(cc_s[g]),
      .tc_o        (tc_hit_s[g])
    );
    assign curr_addr[g*ADDR_W +: ADDR_W]    = ca_s[g];
    assign curr_count[g*COUNT_W +: COUNT_W] = cc_s[g];
  end

  // Next-state for global registers, byte pointer and read data.
  always_comb begin
    mode_d    = mode_q;
    command_d = command_q;
    mask_d    = mask_q;
    sw_req_d  = sw_req_q;
    rdata_d   = rdata_q;

    if (chan_acc_s && (sel_s == SEL_ADDR)) begin
      ptr_d = next_ptr(ptr_q, LAST_A);
    end else if (chan_acc_s && (sel_s == SEL_COUNT)) begin
      ptr_d = next_ptr(ptr_q, LAST_C);
    end else if (ctrl_wr_s && (off_s == OFF_CLR_PTR)) begin
      ptr_d = 2'd0;
    end else begin
      ptr_d = ptr_q;
    end

    for (int c = 0; c < NUM_CH; c++) begin
      if (chan_wr_s && (sel_s == SEL_MODE) && (ch_s == CH_W'(c))) begin
        mode_d[c*MODE_W +: MODE_W] = wmode_s;
      end else begin
        mode_d[c*MODE_W +: MODE_W] = mode_q[c*MODE_W +: MODE_W];
      end
    end

    if (ctrl_wr_s) begin
      case (off_s)
        OFF_CMD:      command_d = cpu_wdata;
        OFF_REQ:      sw_req_d[cpu_wdata[CH_W-1:0]] = cpu_wdata[7];
        OFF_MASK:     mask_d[cpu_wdata[CH_W-1:0]] = cpu_wdata[7];
        OFF_CLR_MASK: mask_d = '0;
        OFF_ALL_MASK: mask_d = cpu_wdata[NUM_CH-1:0];
        default:      command_d = command_q;
      endcase
    end else begin
      command_d = command_q;
    end

    if (ctrl_rd_s && (off_s == OFF_CMD)) begin
      tc_d = '0;
    end else begin
      tc_d = tc_q;
    end

    // Terminal-count effects are applied last so a TC in the read cycle survives.
    tc_d     = tc_d | tc_hit_s;
    sw_req_d = sw_req_d & ~tc_hit_s;
    mask_d   = mask_d | (tc_hit_s & ~autoinit_s);

    if (rd_s) begin
      if (ctrl_s) begin
        case (off_s)
          OFF_CMD: rdata_d = 8'(tc_q);
          OFF_REQ: rdata_d = 8'(sw_req_q);
          default: rdata_d = 8'h00;
        endcase
      end else begin
        case (sel_s)
          SEL_ADDR:  rdata_d = get_byte(32'(ca_s[ch_s]), ptr_q);
          SEL_COUNT: rdata_d = get_byte(32'(cc_s[ch_s]), ptr_q);
          SEL_MODE:  rdata_d = {2'b00, mode_q[ch_s*MODE_W +: MODE_W]};
          default:   rdata_d = 8'h00;
        endcase
      end
    end else begin
      rdata_d = rdata_q;
    end

    if (mclr_s) begin
      mode_d     = '0;
      command_d  = 8'h00;
      mask_d     = '1;
      sw_req_d   = '0;
      tc_d       = '0;
      ptr_d      = 2'd0;
      tc_pulse_d = '0;
      rdata_d    = 8'h00;
    end else begin
      tc_pulse_d = tc_hit_s;
    end
  end

  // Global register state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mode_q     <= '0;
      command_q  <= 8'h00;
      mask_q     <= '1;
      sw_req_q   <= '0;
      tc_q       <= '0;
      ptr_q      <= 2'd0;
      tc_pulse_q <= '0;
      rdata_q    <= 8'h00;
    end else begin
      mode_q     <= mode_d;
      command_q  <= command_d;
      mask_q     <= mask_d;
      sw_req_q   <= sw_req_d;
      tc_q       <= tc_d;
      ptr_q      <= ptr_d;
      tc_pulse_q <= tc_pulse_d;
      rdata_q    <= rdata_d;
    end
  end

  assign mode      = mode_q;
  assign command   = command_q;
  assign mask      = mask_q;
  assign sw_req    = sw_req_q;
  assign tc_pulse  = tc_pulse_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_dma_reg_file.sv
// Self-checking bench for dma_reg_file: a 4-channel/16-bit instance and an
// 8-channel/24-bit-address instance driven from register-access tables and sequences.
module tb_dma_reg_file;

  logic        CLK, RESET;

  logic        a_wr, a_rd, a_upd;
  logic [4:0]  a_addr;
  logic [7:0]  a_wdata, a_rdata, a_cmd;
  logic [1:0]  a_upd_ch;
  logic [63:0] a_caddr, a_ccount;
  logic [23:0] a_mode;
  logic [3:0]  a_mask, a_swreq, a_tcp;

  logic         b_wr, b_rd, b_upd;
  logic [5:0]   b_addr;
  logic [7:0]   b_wdata, b_rdata, b_cmd;
  logic [2:0]   b_upd_ch;
  logic [191:0] b_caddr;
  logic [127:0] b_ccount;
  logic [47:0]  b_mode;
  logic [7:0]   b_mask, b_swreq, b_tcp;

  dma_reg_file dut_a (
    .CLK(CLK), .RESET(RESET), .cpu_wr(a_wr), .cpu_rd(a_rd), .cpu_addr(a_addr),
    .cpu_wdata(a_wdata), .cpu_rdata(a_rdata), .upd_valid(a_upd), .upd_ch(a_upd_ch),
    .curr_addr(a_caddr), .curr_count(a_ccount), .mode(a_mode), .command(a_cmd),
    .mask(a_mask), .sw_req(a_swreq), .tc_pulse(a_tcp)
  );

  dma_reg_file #(.NUM_CH(8), .ADDR_W(24), .COUNT_W(16)) dut_b (
    .CLK(CLK), .RESET(RESET), .cpu_wr(b_wr), .cpu_rd(b_rd), .cpu_addr(b_addr),
    .cpu_wdata(b_wdata), .cpu_rdata(b_rdata), .upd_valid(b_upd), .upd_ch(b_upd_ch),
    .curr_addr(b_caddr), .curr_count(b_ccount), .mode(b_mode), .command(b_cmd),
    .mask(b_mask), .sw_req(b_swreq), .tc_pulse(b_tcp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic [3:0] exp_mask;
  } vec_t;

  typedef struct {
    bit         b;
    logic [7:0] exp;
    string      name;
  } sb_t;

  vec_t vt [22];
  sb_t  sb_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    a_wr = 1'b0; a_rd = 1'b0; a_addr = 5'h00; a_wdata = 8'h00; a_upd = 1'b0; a_upd_ch = 2'd0;
    b_wr = 1'b0; b_rd = 1'b0; b_addr = 6'h00; b_wdata = 8'h00; b_upd = 1'b0; b_upd_ch = 3'd0;
  endtask

  task automatic op(input bit b, input bit wr, input bit rd, input logic [5:0] addr,
                    input logic [7:0] data, input bit upd, input logic [1:0] uch);
    if (b) begin
      b_wr = wr; b_rd = rd; b_addr = addr; b_wdata = data;
    end else begin
      a_wr = wr; a_rd = rd; a_addr = addr[4:0]; a_wdata = data; a_upd = upd; a_upd_ch = uch;
    end
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic wr(input bit b, input logic [5:0] addr, input logic [7:0] data);
    op(b, 1'b1, 1'b0, addr, data, 1'b0, 2'd0);
  endtask

  task automatic upd(input logic [1:0] ch);
    op(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, ch);
  endtask

  task automatic rd(input bit b, input logic [5:0] addr, input logic [7:0] exp, input string name,
                    input bit u, input logic [1:0] uch);
    sb_t e;
    sb_q.push_back('{b: b, exp: exp, name: name});
    op(b, 1'b0, 1'b1, addr, 8'h00, u, uch);
    e = sb_q.pop_front();
    chk(e.name, e.b ? 32'(b_rdata) : 32'(a_rdata), 32'(e.exp));
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 5'h13, 8'h00, 8'h00, 4'hF};
    vt[1]  = '{1'b1, 1'b0, 5'h08, 8'h34, 8'h00, 4'hF};
    vt[2]  = '{1'b1, 1'b0, 5'h08, 8'h12, 8'h00, 4'hF};
    vt[3]  = '{1'b0, 1'b1, 5'h08, 8'h00, 8'h34, 4'hF};
    vt[4]  = '{1'b0, 1'b1, 5'h08, 8'h00, 8'h12, 4'hF};
    vt[5]  = '{1'b1, 1'b0, 5'h10, 8'hA5, 8'h00, 4'hF};
    vt[6]  = '{1'b1, 1'b0, 5'h06, 8'h3F, 8'h00, 4'hF};
    vt[7]  = '{1'b0, 1'b1, 5'h06, 8'h00, 8'h3F, 4'hF};
    vt[8]  = '{1'b1, 1'b0, 5'h03, 8'h55, 8'h00, 4'hF};
    vt[9]  = '{1'b0, 1'b1, 5'h03, 8'h00, 8'h00, 4'hF};
    vt[10] = '{1'b1, 1'b0, 5'h11, 8'h82, 8'h00, 4'hF};
    vt[11] = '{1'b0, 1'b1, 5'h11, 8'h00, 8'h04, 4'hF};
    vt[12] = '{1'b1, 1'b0, 5'h11, 8'h80, 8'h00, 4'hF};
    vt[13] = '{1'b1, 1'b0, 5'h11, 8'h02, 8'h00, 4'hF};
    vt[14] = '{1'b0, 1'b1, 5'h11, 8'h00, 8'h01, 4'hF};
    vt[15] = '{1'b1, 1'b0, 5'h15, 8'h00, 8'h00, 4'h0};
    vt[16] = '{1'b1, 1'b0, 5'h12, 8'h83, 8'h00, 4'h8};
    vt[17] = '{1'b1, 1'b0, 5'h12, 8'h81, 8'h00, 4'hA};
    vt[18] = '{1'b1, 1'b0, 5'h12, 8'h03, 8'h00, 4'h2};
    vt[19] = '{1'b1, 1'b0, 5'h16, 8'h05, 8'h00, 4'h5};
    vt[20] = '{1'b1, 1'b1, 5'h10, 8'h00, 8'h00, 4'h5};
    vt[21] = '{1'b1, 1'b0, 5'h15, 8'h00, 8'h00, 4'h0};

    idle();
    RESET = 1'b0;
    #12;
    chk("reset_mask", 32'(a_mask), 32'hF);
    chk("reset_caddr", a_caddr[31:0] | a_caddr[63:32], 32'h0);
    chk("reset_ccount", a_ccount[31:0] | a_ccount[63:32], 32'h0);
    chk("reset_mode", 32'(a_mode), 32'h0);
    chk("reset_cmd_req_tcp_rdata", {a_cmd, 4'h0, a_swreq, 4'h0, a_tcp, a_rdata}, 32'h0);
    chk("reset_mask_b", 32'(b_mask), 32'hFF);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 22; i++) begin
      if (vt[i].rd && !vt[i].wr) begin
        rd(1'b0, {1'b0, vt[i].addr}, vt[i].exp_rdata, $sformatf("vec%0d_rdata", i), 1'b0, 2'd0);
      end else begin
        op(1'b0, vt[i].wr, vt[i].rd, {1'b0, vt[i].addr}, vt[i].wdata, 1'b0, 2'd0);
      end
      chk($sformatf("vec%0d_mask", i), 32'(vt[i].exp_mask), 32'(a_mask));
    end
    chk("command_kept", 32'(a_cmd), 32'hA5);
    chk("ch2_addr", 32'(a_caddr[32 +: 16]), 32'h1234);

    // Channel 1: count 2, increment, no autoinit, three transfers.
    wr(1'b0, 6'h13, 8'h00);
    wr(1'b0, 6'h05, 8'h02);
    wr(1'b0, 6'h05, 8'h00);
    chk("ch1_count_load", 32'(a_ccount[16 +: 16]), 32'h0002);
    wr(1'b0, 6'h06, 8'h00);
    wr(1'b0, 6'h11, 8'h81);
    chk("swreq_set", 32'(a_swreq), 32'h3);
    for (int i = 0; i < 3; i++) begin
      upd(2'd1);
      chk($sformatf("ch1_count_upd%0d", i), 32'(a_ccount[16 +: 16]),
          (i == 0) ? 32'h1 : (i == 1) ? 32'h0 : 32'hFFFF);
      chk($sformatf("tc_pulse_upd%0d", i), 32'(a_tcp), (i == 2) ? 32'h2 : 32'h0);
    end
    chk("ch1_addr_inc", 32'(a_caddr[16 +: 16]), 32'h3);
    chk("ch1_mask_set", 32'(a_mask), 32'h2);
    chk("ch1_swreq_clr", 32'(a_swreq), 32'h1);
    op(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 2'd0);
    chk("tc_pulse_one_cycle", 32'(a_tcp), 32'h0);
    rd(1'b0, 6'h10, 8'h02, "tc_read_first", 1'b0, 2'd0);
    rd(1'b0, 6'h10, 8'h00, "tc_read_cleared", 1'b0, 2'd0);

    // Channel 0: autoinit + decrement reload at terminal count.
    wr(1'b0, 6'h02, 8'h0C);
    wr(1'b0, 6'h13, 8'h00);
    wr(1'b0, 6'h00, 8'h10);
    wr(1'b0, 6'h00, 8'h00);
    wr(1'b0, 6'h01, 8'h00);
    wr(1'b0, 6'h01, 8'h00);
    upd(2'd0);
    chk("ch0_tc_pulse", 32'(a_tcp), 32'h1);
    chk("ch0_addr_reload", 32'(a_caddr[0 +: 16]), 32'h0010);
    chk("ch0_count_reload", 32'(a_ccount[0 +: 16]), 32'h0000);
    chk("ch0_autoinit_no_mask", 32'(a_mask), 32'h2);
    wr(1'b0, 6'h01, 8'h05);
    wr(1'b0, 6'h01, 8'h00);
    upd(2'd0);
    chk("ch0_addr_dec", 32'(a_caddr[0 +: 16]), 32'h000F);
    chk("ch0_count_dec", 32'(a_ccount[0 +: 16]), 32'h0004);

    // TC flag read in the same cycle a new TC lands on channel 2.
    rd(1'b0, 6'h10, 8'h01, "tc_read_with_new_tc", 1'b1, 2'd2);
    chk("ch2_tc_pulse", 32'(a_tcp), 32'h4);
    chk("ch2_mask_set", 32'(a_mask), 32'h6);
    chk("ch2_addr_inc", 32'(a_caddr[32 +: 16]), 32'h1235);
    rd(1'b0, 6'h10, 8'h04, "tc_survived", 1'b0, 2'd0);
    rd(1'b0, 6'h10, 8'h00, "tc_read_empty", 1'b0, 2'd0);

    // Channel 3: CPU write and transfer collide.
    wr(1'b0, 6'h13, 8'h00);
    wr(1'b0, 6'h0D, 8'h05);
    wr(1'b0, 6'h0D, 8'h00);
    op(1'b0, 1'b1, 1'b0, 6'h0C, 8'h77, 1'b1, 2'd3);
    chk("ch3_addr_cpu_wins", 32'(a_caddr[48 +: 16]), 32'h0077);
    chk("ch3_count_dec", 32'(a_ccount[48 +: 16]), 32'h0004);
    op(1'b0, 1'b1, 1'b0, 6'h0D, 8'h09, 1'b1, 2'd3);
    chk("ch3_count_cpu_wins", 32'(a_ccount[48 +: 16]), 32'h0904);
    chk("ch3_addr_inc", 32'(a_caddr[48 +: 16]), 32'h0078);

    // Master clear.
    wr(1'b0, 6'h14, 8'h00);
    chk("mclr_mask", 32'(a_mask), 32'hF);
    chk("mclr_caddr", a_caddr[31:0] | a_caddr[63:32], 32'h0);
    chk("mclr_ccount", a_ccount[31:0] | a_ccount[63:32], 32'h0);
    chk("mclr_mode_cmd_req", {a_mode, a_cmd} | 32'(a_swreq), 32'h0);
    rd(1'b0, 6'h10, 8'h00, "mclr_tc", 1'b0, 2'd0);

    // Eight channels, three-byte address register.
    wr(1'b1, 6'h23, 8'h00);
    wr(1'b1, 6'h14, 8'h11);
    wr(1'b1, 6'h14, 8'h22);
    wr(1'b1, 6'h14, 8'h33);
    rd(1'b1, 6'h14, 8'h11, "b_addr_byte0", 1'b0, 2'd0);
    rd(1'b1, 6'h14, 8'h22, "b_addr_byte1", 1'b0, 2'd0);
    rd(1'b1, 6'h14, 8'h33, "b_addr_byte2", 1'b0, 2'd0);
    chk("b_ch5_addr", 32'(b_caddr[5*24 +: 24]), 32'h332211);
    wr(1'b1, 6'h21, 8'h87);
    chk("b_swreq_ch7", 32'(b_swreq), 32'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
